gray_cntr_arbiter: RTL and testbench
====================================

// Module: gray_cntr_arbiter
// PURPOSE
//  Shares one parameterized Gray counter among NREQ requesters. Each requester
//  asks for a burst of len counts. A round-robin arbiter grants one requester at
//  a time, runs the Gray sequence from 0 for that burst, then reports completion.
//  Sits between the client blocks and any Gray-indexed resource (buffer
//  pointers, cross-domain count buses).
// PARAMETERS
//  width  4  Gray counter width; burst length range 1..2**width
//  nreq   3  number of requesters (2..8)
// PORTS
//  clk       in   1            rising-edge clock
//  reset     in   1            synchronous, active-low reset
//  req       in   nreq         per-requester request level; held until done
//  len       in   nreq*width   burst lengths, requester r at [r*width +: width]; 0 = 2**width
//  cen       in   1            count enable; 0 freezes the counter during RUN
//  gnt       out  nreq         one-hot grant, high for the whole RUN
//  busy      out  1            high in RUN and DONE
//  count     out  width        registered Gray count of the active burst
//  cnt_valid out  1            high in RUN when count is a live value
//  done      out  1            one-cycle pulse at end of burst
//  done_id   out  clog2(nreq)  requester index for done; holds last value
//  abort     out  1            qualifies done: burst was cut short
// BEHAVIOUR
//  Reset (reset==0 at a clk edge): state=IDLE; gnt=0, busy=0, count=0,
//   cnt_valid=0, done=0, done_id=0, abort=0; RR pointer=0. Reset mid-burst drops
//   the grant with no done pulse.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: at an edge with req!=0, the winner is the first set req bit searching
//   upward from the RR pointer, with wrap-around. At that edge: gnt=onehot(winner),
//   len_q=len[winner], bin=0, count=0; pointer=(winner+1)%nreq; go to RUN.
//   gnt is visible one cycle after req is sampled. Requests arriving in RUN or
//   DONE wait for IDLE.
//  RUN: cnt_valid=1. Internal binary counter bin; count=bin^(bin>>1) is
//   registered and updated in the same edge as bin. Exactly one count bit
//   toggles per advance.
//   - cen=1 and bin!=last: bin++ and count advances. last=len_q-1, computed
//     mod 2**width, so len_q=0 gives last=all-ones (full wrap).
//   - cen=1 and bin==last: go to DONE; done=1, abort=0. count holds.
//   - cen=0: all values hold; no progress.
//   - req[granted]==0, at any edge: go to DONE, done=1, abort=1. This takes
//     priority over completion in the same cycle.
//  DONE (one cycle): gnt=0, cnt_valid=0, busy=1; done/abort valid; done_id=granted
//   index. The next edge goes to IDLE, which clears done and abort and resets
//   count to 0. Minimum gap between bursts is 2 idle cycles.
//  len changes after the grant are ignored (len_q is latched). A burst of len=1
//   emits count=0 for one cen cycle, then done.
//  Output invariant: gnt is one-hot or zero. done and cnt_valid are never high
//   together.
// TESTING
//  1 reset=0 for 2 clk with req=3'b111 -> all outputs 0; after release gnt=3'b001
//    one cycle later.
//  2 width=4, len0=5, cen=1 -> count 0,1,3,2,6 on successive cycles, then done=1,
//    done_id=0, abort=0, gnt=0.
//  3 req=3'b111 held with len=2 each -> grant order 0,1,2,0; each done_id matches
//    the grant just released.
//  4 len1=0, only req[1] set -> 16 Gray codes ending 4'b1000, one bit changes per
//    step, then done.
//  5 cen toggled 1,0,0,1 during RUN -> count holds on the cen=0 cycles; total
//    advances equal len-1.
//  6 req[2] dropped mid-burst at count=4'b0011 -> next edge done=1, abort=1,
//    done_id=2; drive reset=0 mid-RUN -> outputs 0, no done pulse.

Source files
------------

// File: rtl/gray_cntr_arbiter.sv
// Round-robin arbiter that lends one Gray counter to nreq requesters: each grant
// runs a Gray burst of len counts starting at 0, then pulses done with the owner id.
module gray_cntr_arbiter #(
  parameter  int width = 4,
  parameter  int nreq  = 3,
  localparam int IDW   = (nreq > 1) ? $clog2(nreq) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [nreq-1:0]       req,
  input  logic [nreq*width-1:0] len,
  input  logic                  cen,
  output logic [nreq-1:0]       gnt,
  output logic                  busy,
  output logic [width-1:0]      count,
  output logic                  cnt_valid,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic                  abort
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [nreq-1:0]  gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [width-1:0] count_q, count_d;
  logic             cnt_valid_q, cnt_valid_d;
  logic             done_q, done_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic             abort_q, abort_d;
  logic [width-1:0] bin_q, bin_d;
  logic [width-1:0] len_q, len_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gid_q, gid_d;

  logic [width-1:0] len_arr [nreq];

  for (genvar gi = 0; gi < nreq; gi++) begin : g_len
    assign len_arr[gi] = len[gi*width +: width];
  end

  // Round-robin pick: first set request at or above ptr_q, wrapping to 0.
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < nreq; i++) begin
      cand = IDW'((int'(ptr_q) + i) % nreq);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  logic [nreq-1:0]  win_onehot;
  logic [IDW-1:0]   ptr_after_win;
  logic [width-1:0] last;
  logic [width-1:0] bin_inc;

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
    ptr_after_win       = (win_idx == IDW'(nreq - 1)) ? '0 : win_idx + IDW'(1);
    // len_q == 0 wraps to all-ones, giving the full 2**width burst.
    last                = len_q - width'(1);
    bin_inc             = bin_q + width'(1);
  end

  logic end_burst;
  logic end_abort;

  always_comb begin
    end_burst = 1'b0;
    end_abort = 1'b0;
    if (state_q == ST_RUN) begin
      if (!req[gid_q]) begin
        end_burst = 1'b1;
        end_abort = 1'b1;
      end else if (cen && (bin_q == last)) begin
        end_burst = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    busy_d      = busy_q;
    count_d     = count_q;
    cnt_valid_d = cnt_valid_q;
    done_d      = done_q;
    done_id_d   = done_id_q;
    abort_d     = abort_q;
    bin_d       = bin_q;
    len_d       = len_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d     = ST_RUN;
          gnt_d       = win_onehot;
          busy_d      = 1'b1;
          cnt_valid_d = 1'b1;
          done_d      = 1'b0;
          abort_d     = 1'b0;
          len_d       = len_arr[win_idx];
          bin_d       = '0;
          count_d     = '0;
          ptr_d       = ptr_after_win;
          gid_d       = win_idx;
        end
      end
      ST_RUN: begin
        if (end_burst) begin
          state_d     = ST_DONE;
          gnt_d       = '0;
          cnt_valid_d = 1'b0;
          done_d      = 1'b1;
          abort_d     = end_abort;
          done_id_d   = gid_q;
        end else if (cen) begin
          bin_d   = bin_inc;
          count_d = bin_inc ^ (bin_inc >> 1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;
        count_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      count_q     <= '0;
      cnt_valid_q <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      abort_q     <= 1'b0;
      bin_q       <= '0;
      len_q       <= '0;
      ptr_q       <= '0;
      gid_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
      cnt_valid_q <= cnt_valid_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      abort_q     <= abort_d;
      bin_q       <= bin_d;
      len_q       <= len_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign count     = count_q;
  assign cnt_valid = cnt_valid_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign abort     = abort_q;

endmodule

// File: tb/tb_gray_cntr_arbiter.sv
// Scoreboard bench for gray_cntr_arbiter: a burst-level driver predicts each
// grant/done transaction; a passive monitor pops and checks on every done pulse.
`timescale 1ns/1ps
module tb_gray_cntr_arbiter;
  localparam int W   = 4;
  localparam int N   = 3;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] len = '0;
  logic           cen = 1'b0;
  logic [N-1:0]   gnt;
  logic           busy;
  logic [W-1:0]   count;
  logic           cnt_valid;
  logic           done;
  logic [IDW-1:0] done_id;
  logic           abort;

  gray_cntr_arbiter #(.width(W), .nreq(N)) dut (
    .clk(clk), .reset(reset), .req(req), .len(len), .cen(cen),
    .gnt(gnt), .busy(busy), .count(count), .cnt_valid(cnt_valid),
    .done(done), .done_id(done_id), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int ab;
    int adv;
    int gnt_cyc;
    int done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   pushed = 0;
  int   dones = 0;
  int   ptr_m = 0;
  bit   mon_en = 0;
  bit   last_rst = 0;

  always @(posedge clk) begin
    cyc++;
    last_rst = reset;
  end

  task automatic check(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic int gray(input int i);
    return i ^ (i >> 1);
  endfunction

  // Monitor: collects the distinct counts of the live burst, checks on done.
  bit   coll = 0;
  int   seq[$];
  int   gid_seen = -1;
  int   start_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    int   ok;
    if (mon_en) begin
      if (!last_rst) begin
        coll = 0;
      end else begin
        check("gnt_onehot0", int'($onehot0(gnt)), 1);
        check("done_and_cnt_valid", int'(done && cnt_valid), 0);
        check("busy_level", int'(busy), int'((gnt != '0) || done));
        check("cnt_valid_level", int'(cnt_valid), int'(gnt != '0));
        if (!busy) check("idle_count", int'(count), 0);
        if (cnt_valid) begin
          if (!coll) begin
            coll = 1;
            seq.delete();
            start_cyc = cyc;
            gid_seen = -1;
            for (int b = 0; b < N; b++) if (gnt[b]) gid_seen = b;
          end
          if (seq.size() == 0 || seq[$] != int'(count)) begin
            if (seq.size() > 0) check("one_bit_step", $countones(seq[$] ^ int'(count)), 1);
            seq.push_back(int'(count));
          end
        end
        if (done) begin
          dones++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: done_id %0d with empty queue (cycle %0d)", done_id, cyc);
          end else begin
            e = exp_q.pop_front();
            check("done_id", int'(done_id), e.id);
            check("abort", int'(abort), e.ab);
            check("done_cycle", cyc, e.done_cyc);
            check("grant_cycle", start_cyc, e.gnt_cyc);
            check("grant_id", gid_seen, e.id);
            check("gnt_at_done", int'(gnt), 0);
            check("count_at_done", int'(count), gray(e.adv));
            check("seq_len", seq.size(), e.adv + 1);
            ok = 1;
            for (int i = 0; i < seq.size(); i++) if (seq[i] != gray(i)) ok = 0;
            check("seq_values", ok, 1);
          end
          coll = 0;
        end
      end
    end
  end

  // Called at a negedge with the DUT due to be IDLE at the next posedge.
  // cut_fix: -1 no abort, -2 random abort, >=0 drop req after that many advances.
  task automatic run_burst(input logic [N-1:0] mask, input int len_fix,
                           input int cut_fix, input bit cen_always);
    int   win;
    int   c;
    int   lw;
    int   big_l;
    int   cut;
    int   adv;
    int   gcyc;
    int   guard;
    exp_t e;
    win = -1;
    adv = 0;
    guard = 0;
    req = mask;
    for (int r = 0; r < N; r++)
      len[r*W +: W] = W'((len_fix >= 0) ? len_fix : $urandom_range(0, (1 << W) - 1));
    for (int i = 0; i < N; i++) begin
      c = (ptr_m + i) % N;
      if (mask[c] && win < 0) win = c;
    end
    ptr_m = (win + 1) % N;
    lw = int'(len[win*W +: W]);
    big_l = (lw == 0) ? (1 << W) : lw;
    if (cut_fix >= 0) cut = cut_fix;
    else if (cut_fix == -2 && $urandom_range(0, 3) == 0) cut = $urandom_range(0, big_l - 1);
    else cut = -1;
    gcyc = cyc + 1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      guard++;
      for (int r = 0; r < N; r++) len[r*W +: W] = W'($urandom_range(0, (1 << W) - 1));
      if (cut >= 0 && adv == cut) begin
        req[win] = 1'b0;
        cen = 1'($urandom_range(0, 1));
        e.id = win; e.ab = 1; e.adv = adv; e.gnt_cyc = gcyc; e.done_cyc = cyc + 1;
        break;
      end
      cen = cen_always || guard > 60 || ($urandom_range(0, 3) != 0);
      if (cen && adv == big_l - 1) begin
        e.id = win; e.ab = 0; e.adv = adv; e.gnt_cyc = gcyc; e.done_cyc = cyc + 1;
        break;
      end
      if (cen) adv++;
      @(posedge clk);
    end
    exp_q.push_back(e);
    pushed++;
    @(posedge clk);
    @(negedge clk);
    req[win] = 1'b0;
    cen = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] m;
    reset = 1'b0;
    req = 3'b111;
    cen = 1'b1;
    for (int r = 0; r < N; r++) len[r*W +: W] = W'(5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", int'(gnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(count), 0);
    check("rst_cnt_valid", int'(cnt_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_done_id", int'(done_id), 0);
    check("rst_abort", int'(abort), 0);
    mon_en = 1;
    reset = 1'b1;

    run_burst(3'b111, 5, -1, 1'b1);
    repeat (3) run_burst(3'b111, 2, -1, 1'b1);
    run_burst(3'b010, 0, -1, 1'b1);
    run_burst(3'b001, 6, -1, 1'b0);
    run_burst(3'b100, 7, 2, 1'b1);

    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) begin
        req = '0;
        @(posedge clk);
        @(negedge clk);
      end
      m = N'($urandom_range(1, (1 << N) - 1));
      run_burst(m, -1, -2, 1'b0);
    end

    // Reset in the middle of a burst: outputs clear, no done pulse, pointer back to 0.
    req = 3'b010;
    len[1*W +: W] = W'(8);
    cen = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_reset_valid", int'(cnt_valid), 1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_gnt", int'(gnt), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_count", int'(count), 0);
    check("midrst_cnt_valid", int'(cnt_valid), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_done_id", int'(done_id), 0);
    check("midrst_abort", int'(abort), 0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_no_done", dones, pushed);
    reset = 1'b1;
    ptr_m = 0;
    run_burst(3'b111, 3, -1, 1'b1);

    check("queue_drained", exp_q.size(), 0);
    check("done_total", dones, pushed);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
